// File: rtl/sync_seq_pkg.sv
// sync_seq_pkg: shared types and tables for the random-sequence checker.
//   state_t    : checker FSM states
//   SUCC       : successor of each 4-bit code in the 8-state cycle (illegal codes map to 0)
//   LEGAL_MASK : bit n set when code n belongs to the sequence
package sync_seq_pkg;
  typedef enum logic [1:0] {HUNT, ACQ, LOCKED} state_t;
  localparam logic [3:0] SUCC [16] = '{
    4'h5, 4'h0, 4'h0, 4'hC, 4'h0, 4'hA, 4'h9, 4'h0,
    4'h0, 4'h3, 4'h6, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0
  };
  localparam logic [15:0] LEGAL_MASK = 16'h9669;
endpackage

// File: rtl/sync_seq_next.sv
// sync_seq_next: combinational successor lookup and legality flag for one 4-bit code.
//   x_i     : code to look up
//   next_o  : successor of x_i in the cycle 0,5,A,6,9,3,C,F
//   legal_o : x_i is a member of the sequence
module sync_seq_next
  import sync_seq_pkg::*;
(
  input  logic [3:0] x_i,
  output logic [3:0] next_o,
  output logic       legal_o
);
  assign next_o  = SUCC[x_i];
  assign legal_o = LEGAL_MASK[x_i];
endmodule

// File: rtl/sync_random_seq_checker.sv
// sync_random_seq_checker: lock/flywheel checker for the 4-bit random-sequence counter.
//   clk       : rising-edge clock
//   clear     : asynchronous active-low reset
//   d_valid   : sample qualifier
//   d         : sampled sequence word
//   locked    : FSM is in LOCKED
//   err       : one-cycle pulse, mismatch while locked
//   illegal   : one-cycle pulse, valid word outside the sequence set
//   expected  : next word the checker expects
//   err_count : saturating err count, present only when SEQ_CHK_ERRCNT_EN is defined
module sync_random_seq_checker
  import sync_seq_pkg::*;
#(
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 2
`ifdef SEQ_CHK_ERRCNT_EN
  ,
  parameter int CNT_W      = 8
`endif
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       d_valid,
  input  logic [3:0] d,
  output logic       locked,
  output logic       err,
  output logic       illegal,
  output logic [3:0] expected
`ifdef SEQ_CHK_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] err_count
`endif
);
  localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_CNT);
  state_t     state_q, state_d;
  logic [3:0] expected_q, expected_d;
  logic [3:0] good_q, good_d;
  logic [3:0] bad_q, bad_d;
  logic       err_q, err_d;
  logic       illegal_q, illegal_d;
  logic [3:0] d_nxt, e_nxt;
  logic       d_legal, e_legal;
  logic       match;
  sync_seq_next u_next_d (.x_i(d),          .next_o(d_nxt), .legal_o(d_legal));
  sync_seq_next u_next_e (.x_i(expected_q), .next_o(e_nxt), .legal_o(e_legal));
  // expected is always a legal code; gating on it keeps a corrupted register from matching
  assign match = (d == expected_q) && e_legal;
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    good_d     = good_q;
    bad_d      = bad_q;
    err_d      = 1'b0;
    illegal_d  = 1'b0;
    if (d_valid) begin
      illegal_d = !d_legal;
      case (state_q)
        HUNT: if (d_legal) begin
          expected_d = d_nxt;
          good_d     = '0;
          state_d    = ACQ;
        end
        ACQ: if (!d_legal) begin
          state_d = HUNT;
          good_d  = '0;
        end else begin
          // a legal mismatch reseeds from d, so expected follows d either way
          expected_d = d_nxt;
          good_d     = match ? good_q + 4'd1 : 4'd0;
          if (match && good_q + 4'd1 == LOCK_C) begin
            state_d = LOCKED;
            bad_d   = '0;
          end
        end
        LOCKED: if (match) begin
          expected_d = d_nxt;
          bad_d      = '0;
        end else begin
          err_d      = 1'b1;
          expected_d = e_nxt;
          bad_d      = bad_q + 4'd1;
          if (bad_q + 4'd1 == UNLOCK_C) begin
            state_d = HUNT;
            good_d  = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q    <= HUNT;
      expected_q <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      err_q      <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      err_q      <= err_d;
      illegal_q  <= illegal_d;
    end
  end
  assign locked   = (state_q == LOCKED);
  assign err      = err_q;
  assign illegal  = illegal_q;
  assign expected = expected_q;
`ifdef SEQ_CHK_ERRCNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = (err_d && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign err_count = cnt_q;
`endif
endmodule

// File: doc/sync_random_seq_checker.md
# sync_random_seq_checker

Receive-side companion to the 4-bit synchronous random-sequence counter. Samples a 4-bit word each valid cycle and checks it against the counter's fixed 8-state cycle. Acquires lock after a run of correct transitions, flywheels through isolated errors, and drops lock after repeated mismatches. Sits at the far end of any link or bus carrying the counter output; reports lock, error, and illegal-code status.

## Interface
- LOCK_CNT, 3: consecutive correct transitions needed to declare lock (1..15)
- UNLOCK_CNT, 2: consecutive mismatches while locked that drop lock (1..15)
- CNT_W, 8: error-counter width
- clk  in  1  rising-edge clock
- clear  in  1  reset, asynchronous, active-low
- d_valid  in  1  sample qualifier
- d  in  4  sampled sequence word, bit order q[3:0]
- locked  out  1  lock status
- err  out  1  one-cycle pulse: mismatch while locked
- illegal  out  1  one-cycle pulse: valid word outside the sequence set
- expected  out  4  next word the checker expects
- err_count  out  CNT_W  saturating error count (only with SEQ_CHK_ERRCNT_EN)

## Operation
- Sequence, hex, cyclic: 0 → 5 → A → 6 → 9 → 3 → C → F → 0. Legal set {0,5,A,6,9,3,C,F}; 1,2,4,7,8,B,D,E are illegal.
- next(x) is the successor in this cycle.
- Cycles with d_valid=0 change no state, counter, or output; err and illegal are driven 0.
- illegal pulses on any valid illegal word, in every state.
- FSM states: HUNT, ACQ, LOCKED. Internal counters: good (0..LOCK_CNT), bad (0..UNLOCK_CNT).
- HUNT: on a valid legal word → expected=next(d), good=0, go to ACQ. Illegal word → stay in HUNT.
- ACQ, valid d==expected: good+1, expected=next(d). When good reaches LOCK_CNT → LOCKED, bad=0.
- ACQ, legal mismatch: reseed with expected=next(d), good=0, stay in ACQ. No err pulse.
- ACQ, illegal word → HUNT.
- LOCKED, match: expected=next(d), bad=0.
- LOCKED, mismatch (legal or illegal): err=1, bad+1, flywheel expected=next(expected).
- LOCKED: when bad reaches UNLOCK_CNT → HUNT, locked=0, good=0.
- Wrap F→0 is an ordinary match.
- err and illegal may pulse in the same cycle.

## Timing
- All outputs registered. Status reflects a sample on the cycle after it is accepted (1-cycle latency).
- locked=1 exactly while the FSM is in LOCKED.
- Reset values: state HUNT, expected=0, locked=0, err=0, illegal=0, err_count=0, good=bad=0.
- clear asserted mid-operation clears everything asynchronously. First sample after release is treated as in HUNT.
- Back-to-back valid samples are supported at full rate. No backpressure.

## Configuration
- SEQ_CHK_ERRCNT_EN defined: err_count present; increments on each err pulse; saturates at all-ones; cleared only by clear.
- SEQ_CHK_ERRCNT_EN undefined: err_count port and counter removed. All other behaviour identical.

## Structure
- Package sync_seq_pkg holds:
  - state enum (HUNT, ACQ, LOCKED)
  - 16-entry successor constant table
  - 16-bit legal-code mask
- Sub-module sync_seq_next: combinational, 4-bit in → next[3:0] and legal. Instantiated twice: once on d, once on expected for flywheel.

## Test plan
- Reset, then valid 0,5,A,6 on consecutive cycles (LOCK_CNT=3) → locked=1 the cycle after the 6 sample; expected=9.
- Locked at expected=9, feed 6 then 3 → err pulses once; err_count=1; expected becomes 3; the 3 matches; locked stays 1; bad clears.
- Locked, feed two consecutive wrong legal words → err pulses twice; locked=0 the cycle after the second; state HUNT.
- In ACQ, feed 7 → illegal pulse, return to HUNT, locked stays 0. Then C,F,0,5 → locked=1 after the 5.
- Locked, F followed by 0 with d_valid low for 3 cycles between them → no err, still locked, expected=5.
- Locked with err_count=2, pulse clear low mid-stream → locked, err_count, and expected read 0 immediately; relock needs LOCK_CNT+1 samples.
